// File: rtl/stash_scan_table_pipe.sv
// stash_scan_table_pipe
//   Stash scan table for path write-back. Each candidate stash block is
//   classified against the current access path and placed at the deepest
//   eligible bucket level that still has room; its stash address is written
//   into a per-path slot table (slot = level*ORAMZ + count[level]). A scan then
//   drains the table in ascending slot order through a valid/ready port,
//   clearing each slot as it is read so the next access needs no re-sweep.
//
// Optional feature macro: STASH_SCAN_STATS_EN
//   When defined, adds AcceptCount/RejectCount saturating 32-bit counters of
//   classification results (cleared only by Reset).
//
// Ports
//   Clock, Reset          clock, synchronous active-high reset
//   PerAccessReset        abort access: clear counters and re-sweep table
//   ResetDone             table swept; classification may start
//   CurrentLeaf           leaf of the path being written back
//   InLeaf/InSAddr        candidate leaf and stash address
//   InValid/InReady       candidate handshake
//   OutSAddr/OutLevel     registered classification result
//   OutAccepted/OutValid  placed flag and result strobe (1 cycle after handshake)
//   ScanStart             pulse: begin draining the table
//   OutSTAddr/OutSTSlot   next non-empty slot content and its index
//   OutSTValid/OutSTReady scan handshake
//   ScanDone              1-cycle pulse after the last slot
//   AcceptCount/RejectCount (STASH_SCAN_STATS_EN only)
module stash_scan_table_pipe #(
    parameter int ORAML        = 16,
    parameter int ORAMZ        = 4,
    parameter int StashEAWidth = 8,
    localparam int LvW     = $clog2(ORAML + 1),
    localparam int BCWidth = $clog2(ORAMZ + 1),
    localparam int Depth   = (ORAML + 1) * ORAMZ,
    localparam int STAW    = $clog2(Depth)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    PerAccessReset,
    output logic                    ResetDone,
    input  logic [ORAML-1:0]        CurrentLeaf,
    input  logic [ORAML-1:0]        InLeaf,
    input  logic [StashEAWidth-1:0] InSAddr,
    input  logic                    InValid,
    output logic                    InReady,
    output logic [StashEAWidth-1:0] OutSAddr,
    output logic [LvW-1:0]          OutLevel,
    output logic                    OutAccepted,
    output logic                    OutValid,
    input  logic                    ScanStart,
    output logic [StashEAWidth-1:0] OutSTAddr,
    output logic [STAW-1:0]         OutSTSlot,
    output logic                    OutSTValid,
    input  logic                    OutSTReady,
`ifdef STASH_SCAN_STATS_EN
    output logic [31:0]             AcceptCount,
    output logic [31:0]             RejectCount,
`endif
    output logic                    ScanDone
);

    localparam logic [StashEAWidth-1:0] SNULL = {StashEAWidth{1'b1}};
    localparam logic [BCWidth-1:0]      Z_B   = BCWidth'(ORAMZ);
    localparam logic [STAW-1:0]         LAST  = STAW'(Depth - 1);

    typedef enum logic [2:0] {INIT, ACCEPT, SCAN_RD, SCAN_OUT, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [STAW-1:0]         ptr_reg, ptr_next;
    logic [BCWidth-1:0]      count_reg [ORAML+1];
    logic [StashEAWidth-1:0] mem [Depth];
    logic [StashEAWidth-1:0] rd_data_reg;

    logic                    mem_we;
    logic [STAW-1:0]         mem_waddr;
    logic [StashEAWidth-1:0] mem_wdata;
    logic                    count_clr;
    logic                    st_valid;
    logic                    in_ready;
    logic                    hs;

    logic [ORAML:0]          open_lvl;
    logic [STAW-1:0]         slot_cand [ORAML+1];
    logic                    place_found;
    logic [LvW-1:0]          place_lvl;
    logic [STAW-1:0]         place_slot;

    logic                    out_valid_reg, out_acc_reg;
    logic [StashEAWidth-1:0] out_saddr_reg;
    logic [LvW-1:0]          out_level_reg;

    // Per-level eligibility (low l leaf bits match) and room; the candidate
    // slot address uses a constant per-level base.
    generate
        for (genvar gi = 0; gi <= ORAML; gi++) begin : g_lvl
            logic elig;
            if (gi == 0) begin : g_root
                assign elig = 1'b1;
            end else begin : g_deep
                assign elig = (InLeaf[gi-1:0] == CurrentLeaf[gi-1:0]);
            end
            assign open_lvl[gi]  = elig && (count_reg[gi] < Z_B);
            assign slot_cand[gi] = STAW'(gi * ORAMZ) + STAW'(count_reg[gi]);
        end
    endgenerate

    // Ascending sweep: the last open level seen is the deepest.
    always_comb begin
        place_found = 1'b0;
        place_lvl   = '0;
        place_slot  = '0;
        for (int l = 0; l <= ORAML; l++) begin
            if (open_lvl[l]) begin
                place_found = 1'b1;
                place_lvl   = LvW'(l);
                place_slot  = slot_cand[l];
            end
        end
    end

    assign in_ready = (state_reg == ACCEPT) && !Reset && !PerAccessReset;
    assign hs       = InValid && in_ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        mem_we     = 1'b0;
        mem_waddr  = ptr_reg;
        mem_wdata  = SNULL;
        count_clr  = 1'b0;
        st_valid   = 1'b0;
        case (state_reg)
            INIT: begin
                mem_we    = 1'b1;
                count_clr = 1'b1;
                ptr_next  = ptr_reg + STAW'(1);
                if (ptr_reg == LAST) begin
                    state_next = ACCEPT;
                    ptr_next   = '0;
                end
            end
            ACCEPT: begin
                if (hs && place_found) begin
                    mem_we    = 1'b1;
                    mem_waddr = place_slot;
                    mem_wdata = InSAddr;
                end
                if (ScanStart) begin
                    state_next = SCAN_RD;
                    ptr_next   = '0;
                end
            end
            SCAN_RD: state_next = SCAN_OUT;
            SCAN_OUT: begin
                st_valid = (rd_data_reg != SNULL);
                // Empty slots are skipped; occupied ones wait for the consumer
                // and are cleared on the handshake.
                if (!st_valid || OutSTReady) begin
                    mem_we     = st_valid;
                    ptr_next   = ptr_reg + STAW'(1);
                    state_next = (ptr_reg == LAST) ? DONE : SCAN_RD;
                end
            end
            DONE: begin
                count_clr  = 1'b1;
                ptr_next   = '0;
                state_next = ACCEPT;
            end
            default: state_next = INIT;
        endcase
        // Abort overrides everything, including a pending scan handshake.
        if (PerAccessReset) begin
            state_next = INIT;
            ptr_next   = '0;
            mem_we     = 1'b0;
            count_clr  = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || count_clr) begin
            for (int l = 0; l <= ORAML; l++) count_reg[l] <= '0;
        end else begin
            for (int l = 0; l <= ORAML; l++) begin
                if (hs && place_found && (place_lvl == LvW'(l)))
                    count_reg[l] <= count_reg[l] + BCWidth'(1);
            end
        end
    end

    // Slot table: one write port, one registered read port.
    always_ff @(posedge Clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (state_reg == SCAN_RD) rd_data_reg <= mem[ptr_reg];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid_reg <= 1'b0;
            out_acc_reg   <= 1'b0;
            out_saddr_reg <= '0;
            out_level_reg <= '0;
        end else begin
            out_valid_reg <= hs;
            if (hs) begin
                out_saddr_reg <= InSAddr;
                out_level_reg <= place_lvl;
                out_acc_reg   <= place_found;
            end
        end
    end

`ifdef STASH_SCAN_STATS_EN
    logic [31:0] accept_cnt_reg, reject_cnt_reg;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            accept_cnt_reg <= '0;
            reject_cnt_reg <= '0;
        end else if (hs) begin
            if (place_found && (accept_cnt_reg != '1))
                accept_cnt_reg <= accept_cnt_reg + 32'd1;
            if (!place_found && (reject_cnt_reg != '1))
                reject_cnt_reg <= reject_cnt_reg + 32'd1;
        end
    end
    assign AcceptCount = accept_cnt_reg;
    assign RejectCount = reject_cnt_reg;
`endif

    assign ResetDone   = !Reset && (state_reg != INIT);
    assign InReady     = in_ready;
    assign OutValid    = out_valid_reg;
    assign OutSAddr    = out_saddr_reg;
    assign OutLevel    = out_level_reg;
    assign OutAccepted = out_acc_reg;
    assign OutSTValid  = st_valid && !Reset;
    assign OutSTAddr   = OutSTValid ? rd_data_reg : '0;
    assign OutSTSlot   = OutSTValid ? ptr_reg : '0;
    assign ScanDone    = (state_reg == DONE) && !Reset;

endmodule

// File: tb/tb_stash_scan_table_pipe.sv
// tb_stash_scan_table_pipe
//   Scoreboard bench for stash_scan_table_pipe with ORAML=3, ORAMZ=2 (8 slots).
//   Classification expectations are queued when a candidate is driven and
//   compared when OutValid appears; scan expectations are queued per slot and
//   compared on each OutSTValid.
module tb_stash_scan_table_pipe;
    localparam int L = 3;
    localparam int Z = 2;
    localparam int AW = 8;

    logic          Clock = 1'b0;
    logic          Reset, PerAccessReset, InValid, ScanStart, OutSTReady;
    logic          ResetDone, InReady, OutAccepted, OutValid, OutSTValid, ScanDone;
    logic [L-1:0]  CurrentLeaf, InLeaf;
    logic [AW-1:0] InSAddr, OutSAddr, OutSTAddr;
    logic [1:0]    OutLevel;
    logic [2:0]    OutSTSlot;
`ifdef STASH_SCAN_STATS_EN
    logic [31:0]   AcceptCount, RejectCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {logic [7:0] saddr; logic [1:0] level; logic acc;} cls_t;
    typedef struct {logic [7:0] addr; logic [2:0] slot;} scn_t;
    cls_t cls_q[$];
    scn_t scn_q[$];

    stash_scan_table_pipe #(.ORAML(L), .ORAMZ(Z), .StashEAWidth(AW)) dut (
        .Clock(Clock), .Reset(Reset), .PerAccessReset(PerAccessReset),
        .ResetDone(ResetDone), .CurrentLeaf(CurrentLeaf), .InLeaf(InLeaf),
        .InSAddr(InSAddr), .InValid(InValid), .InReady(InReady),
        .OutSAddr(OutSAddr), .OutLevel(OutLevel), .OutAccepted(OutAccepted),
        .OutValid(OutValid), .ScanStart(ScanStart), .OutSTAddr(OutSTAddr),
        .OutSTSlot(OutSTSlot), .OutSTValid(OutSTValid), .OutSTReady(OutSTReady),
`ifdef STASH_SCAN_STATS_EN
        .AcceptCount(AcceptCount), .RejectCount(RejectCount),
`endif
        .ScanDone(ScanDone)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_cls(input logic [7:0] s, input logic [1:0] lv, input logic a);
        cls_t e;
        e.saddr = s; e.level = lv; e.acc = a;
        cls_q.push_back(e);
    endtask

    task automatic push_scn(input logic [7:0] a, input logic [2:0] s);
        scn_t e;
        e.addr = a; e.slot = s;
        scn_q.push_back(e);
    endtask

    // Drive one candidate for a single cycle; result is checked the next cycle.
    task automatic drive_class(input logic [2:0] leaf, input logic [7:0] saddr);
        cls_t e;
        InValid = 1'b1; InLeaf = leaf; InSAddr = saddr;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL in_ready saddr=%h: got %b want 1", saddr, InReady);
        end
        tick();
        InValid = 1'b0;
        checks++;
        if (OutValid !== 1'b1 || cls_q.size() == 0) begin
            errors++;
            $display("FAIL class_valid saddr=%h: OutValid=%b queued=%0d", saddr, OutValid, cls_q.size());
        end else begin
            e = cls_q.pop_front();
            if ({OutSAddr, OutLevel, OutAccepted} !== {e.saddr, e.level, e.acc}) begin
                errors++;
                $display("FAIL class_result: got saddr=%h lvl=%0d acc=%b want saddr=%h lvl=%0d acc=%b",
                         OutSAddr, OutLevel, OutAccepted, e.saddr, e.level, e.acc);
            end
        end
    endtask

    // Pulse ScanStart and drain for a fixed window; ready stays low for the
    // first 'hold' cycles of the window.
    task automatic run_scan(input int hold, input int exp_dones, input string tag);
        int dones;
        logic pend;
        logic [7:0] pa;
        logic [2:0] ps;
        scn_t e;
        dones = 0; pend = 1'b0; pa = '0; ps = '0;
        ScanStart = 1'b1; OutSTReady = 1'b0;
        tick();
        ScanStart = 1'b0;
        for (int c = 0; c < 40; c++) begin
            OutSTReady = (c >= hold);
            if (pend) begin
                checks++;
                if (!(OutSTValid === 1'b1 && OutSTAddr === pa && OutSTSlot === ps)) begin
                    errors++;
                    $display("FAIL %s scan_hold: got v=%b a=%h s=%0d want v=1 a=%h s=%0d",
                             tag, OutSTValid, OutSTAddr, OutSTSlot, pa, ps);
                end
            end
            pend = 1'b0;
            if (OutSTValid === 1'b1) begin
                checks++;
                if (scn_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s scan_extra: got a=%h s=%0d want no output", tag, OutSTAddr, OutSTSlot);
                end else begin
                    e = scn_q[0];
                    if (OutSTAddr !== e.addr || OutSTSlot !== e.slot) begin
                        errors++;
                        $display("FAIL %s scan_data: got a=%h s=%0d want a=%h s=%0d",
                                 tag, OutSTAddr, OutSTSlot, e.addr, e.slot);
                    end
                    if (OutSTReady) void'(scn_q.pop_front());
                    else begin pend = 1'b1; pa = OutSTAddr; ps = OutSTSlot; end
                end
            end
            if (ScanDone === 1'b1) dones++;
            tick();
        end
        OutSTReady = 1'b0;
        checks++;
        if (dones != exp_dones) begin
            errors++;
            $display("FAIL %s scan_done_count: got %0d want %0d", tag, dones, exp_dones);
        end
        checks++;
        if (scn_q.size() != 0) begin
            errors++;
            $display("FAIL %s scan_missing: got %0d entries left want 0", tag, scn_q.size());
        end
        scn_q.delete();
        $display("scan %s: done pulses=%0d", tag, dones);
    endtask

    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (ResetDone !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL %s init_cycles: got %0d want 8", tag, n);
        end
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_after_init: got %b want 1", tag, InReady);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ResetDone, InReady, OutValid, OutAccepted, OutSTValid, ScanDone, OutSAddr, OutLevel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b ir=%b ov=%b oa=%b stv=%b sd=%b sa=%h lv=%0d want all 0",
                     ResetDone, InReady, OutValid, OutAccepted, OutSTValid, ScanDone, OutSAddr, OutLevel);
        end
        Reset = 1'b0;
        count_init("reset");
        $display("reset: ResetDone=%b", ResetDone);
    endtask

    task automatic test_fill_all();
        logic [1:0] lv [9];
        logic [2:0] sl [8];
        lv = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        sl = '{3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1};
        CurrentLeaf = 3'b101;
        for (int i = 0; i < 9; i++) begin
            push_cls(8'h40 + 8'(i), lv[i], (i < 8));
            drive_class(3'b101, 8'h40 + 8'(i));
            $display("class fill #%0d: lvl=%0d acc=%b", i, OutLevel, OutAccepted);
        end
        tick();
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL out_valid_idle: got %b want 0", OutValid);
        end
        // Expected contents in ascending slot order.
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 8; i++) if (sl[i] == 3'(s)) push_scn(8'h40 + 8'(i), 3'(s));
        end
        run_scan(0, 1, "fill");
    endtask

    task automatic test_reject();
        CurrentLeaf = 3'b101;
        push_cls(8'h51, 2'd0, 1'b1);
        drive_class(3'b100, 8'h51);
        push_cls(8'h52, 2'd0, 1'b1);
        drive_class(3'b100, 8'h52);
        push_cls(8'h53, 2'd0, 1'b0);
        drive_class(3'b100, 8'h53);
        $display("class reject: third acc=%b", OutAccepted);
        push_scn(8'h51, 3'd0);
        push_scn(8'h52, 3'd1);
        run_scan(0, 1, "reject");
    endtask

    task automatic test_backpressure();
        CurrentLeaf = 3'b101;
        push_cls(8'h11, 2'd0, 1'b1);
        drive_class(3'b100, 8'h11);
        push_cls(8'h22, 2'd3, 1'b1);
        drive_class(3'b101, 8'h22);
        push_scn(8'h11, 3'd0);
        push_scn(8'h22, 3'd6);
        run_scan(5, 1, "backpressure");
    endtask

    task automatic test_rescan();
        run_scan(0, 1, "rescan");
    endtask

    task automatic test_per_access_reset();
        int n;
        CurrentLeaf = 3'b101;
        push_cls(8'h31, 2'd3, 1'b1);
        drive_class(3'b101, 8'h31);
        push_cls(8'h32, 2'd3, 1'b1);
        drive_class(3'b101, 8'h32);
        ScanStart = 1'b1; OutSTReady = 1'b0;
        tick();
        ScanStart = 1'b0;
        n = 0;
        while (OutSTValid !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (OutSTValid !== 1'b1 || OutSTAddr !== 8'h31 || OutSTSlot !== 3'd6) begin
            errors++;
            $display("FAIL par_first_out: got v=%b a=%h s=%0d want v=1 a=31 s=6", OutSTValid, OutSTAddr, OutSTSlot);
        end
        PerAccessReset = 1'b1; OutSTReady = 1'b1;
        tick();
        PerAccessReset = 1'b0; OutSTReady = 1'b0;
        checks++;
        if (OutSTValid !== 1'b0 || ResetDone !== 1'b0) begin
            errors++;
            $display("FAIL par_drop: got stv=%b rd=%b want 0 0", OutSTValid, ResetDone);
        end
        count_init("par");
        push_cls(8'h33, 2'd3, 1'b1);
        drive_class(3'b101, 8'h33);
        $display("class after par: lvl=%0d acc=%b", OutLevel, OutAccepted);
        push_scn(8'h33, 3'd6);
        run_scan(0, 1, "par");
    endtask

    initial begin
        Reset = 1'b1; PerAccessReset = 1'b0; InValid = 1'b0; ScanStart = 1'b0;
        OutSTReady = 1'b0; CurrentLeaf = '0; InLeaf = '0; InSAddr = '0;
        test_reset();
        test_fill_all();
        test_reject();
        test_backpressure();
        test_rescan();
        test_per_access_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
